// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - round sequencer feeding the game timer, with BCD score and high score
module game_round_controller #(
  parameter int OVER_HOLD_CYCLES = 150_000_000,
  parameter int SCORE_MAX_TENS   = 9
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       start_key,
  input  logic       hit_pulse,
  input  logic       time_up,
  output logic       game_start,
  output logic       timer_clear,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [3:0] high_ones,
  output logic [3:0] high_tens,
  output logic       new_high,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int                HOLD_W    = $clog2(OVER_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD_CYCLES - 1);
  localparam logic [3:0]        MAX_TENS  = 4'(SCORE_MAX_TENS);

  state_t            cur_state, nxt_state;
  logic              sync_1, sync_2, sync_3;
  logic              start_rise;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              game_start_n, timer_clear_n, new_high_n;
  logic [3:0]        score_ones_n, score_tens_n, high_ones_n, high_tens_n;
  logic [3:0]        inc_ones, inc_tens, hit_ones, hit_tens;
  logic              beats_high;

  assign start_rise = sync_2 & ~sync_3;
  assign state      = cur_state;

  // Score after this cycle's hit, saturating at the maximum instead of wrapping.
  always_comb begin
    inc_ones = score_ones;
    inc_tens = score_tens;
    if (!((score_tens == MAX_TENS) && (score_ones == 4'd9))) begin
      if (score_ones == 4'd9) begin
        inc_ones = 4'd0;
        inc_tens = score_tens + 4'd1;
      end else begin
        inc_ones = score_ones + 4'd1;
      end
    end
    hit_ones   = hit_pulse ? inc_ones : score_ones;
    hit_tens   = hit_pulse ? inc_tens : score_tens;
    beats_high = (hit_tens > high_tens) ||
                 ((hit_tens == high_tens) && (hit_ones > high_ones));
  end

  always_comb begin
    nxt_state     = cur_state;
    game_start_n  = game_start;
    timer_clear_n = 1'b0;
    new_high_n    = new_high;
    score_ones_n  = score_ones;
    score_tens_n  = score_tens;
    high_ones_n   = high_ones;
    high_tens_n   = high_tens;
    hold_cnt_n    = hold_cnt;
    case (cur_state)
      IDLE: begin
        game_start_n = 1'b0;
        if (start_rise) begin
          nxt_state     = PLAYING;
          game_start_n  = 1'b1;
          timer_clear_n = 1'b1;
          new_high_n    = 1'b0;
          score_ones_n  = 4'd0;
          score_tens_n  = 4'd0;
        end
      end
      PLAYING: begin
        game_start_n = 1'b1;
        score_ones_n = hit_ones;
        score_tens_n = hit_tens;
        // While timer_clear is high the timer still shows last round's value.
        if (time_up && !timer_clear) begin
          nxt_state    = GAME_OVER;
          game_start_n = 1'b0;
          hold_cnt_n   = '0;
          if (beats_high) begin
            high_ones_n = hit_ones;
            high_tens_n = hit_tens;
            new_high_n  = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        game_start_n = 1'b0;
        hold_cnt_n   = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state    = IDLE;
        game_start_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      cur_state   <= IDLE;
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      sync_3      <= 1'b0;
      hold_cnt    <= '0;
      game_start  <= 1'b0;
      timer_clear <= 1'b0;
      new_high    <= 1'b0;
      score_ones  <= 4'd0;
      score_tens  <= 4'd0;
      high_ones   <= 4'd0;
      high_tens   <= 4'd0;
    end else begin
      cur_state   <= nxt_state;
      sync_1      <= start_key;
      sync_2      <= sync_1;
      sync_3      <= sync_2;
      hold_cnt    <= hold_cnt_n;
      game_start  <= game_start_n;
      timer_clear <= timer_clear_n;
      new_high    <= new_high_n;
      score_ones  <= score_ones_n;
      score_tens  <= score_tens_n;
      high_ones   <= high_ones_n;
      high_tens   <= high_tens_n;
    end
  end

endmodule
